// File: rtl/lighthouse_pkg.sv
// lighthouse_pkg
//   Shared types and record layout for the lighthouse pulse capture block.
//   A record is packed MSB->LSB as {sensor, start timestamp, width}.
package lighthouse_pkg;

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_IDLE     = 2'd1,
    S_ACTIVE   = 2'd2
  } sense_state_e;

  localparam int DEF_SENSORS  = 2;
  localparam int DEF_TS_WIDTH = 24;
  localparam int DEF_W_WIDTH  = 16;

  // Sensor index field is at least one bit so a single-sensor build still
  // has a legal port.
  function automatic int sensor_idx_w(input int sensors);
    return (sensors > 1) ? $clog2(sensors) : 1;
  endfunction

  function automatic int rec_w(input int sensors, input int ts_w, input int w_w);
    return sensor_idx_w(sensors) + ts_w + w_w;
  endfunction

  localparam int REC_W = rec_w(DEF_SENSORS, DEF_TS_WIDTH, DEF_W_WIDTH);

endpackage

// File: rtl/pulse_fifo.sv
// pulse_fifo
//   Synchronous first-word-fall-through FIFO holding packed pulse records.
//   Ports:
//     clk, reset     clock, async active-high reset
//     push_i, din_i  write request / data (ignored when full unless popping)
//     pop_i          remove head (ignored when empty)
//     dout_o         head record, zero while empty
//     full_o, empty_o
module pulse_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pulse_capture.sv
// pulse_capture
//   Timestamps low-going envelope pulses from TS4231 receivers and queues
//   {sensor, start, width} records in a FWFT FIFO.
//   Ports:
//     clk, reset      24 MHz clock, async active-high reset
//     e               async envelope lines, low = light present
//     pulse_valid/ready, pulse_sensor/ts/width   record stream out
//     overflow        sticky: a pending record was overwritten
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   S_DISARMED | line not yet seen high since reset; ignore edges
//   S_IDLE     | line high, waiting for falling edge
//   S_ACTIVE   | line low, start timestamp latched, waiting for rise
module pulse_capture
  import lighthouse_pkg::*;
#(
  parameter int SENSORS   = 2,
  parameter int TS_WIDTH  = 24,
  parameter int W_WIDTH   = 16,
  parameter int MIN_WIDTH = 2,
  parameter int DEPTH     = 8,
  localparam int SW       = sensor_idx_w(SENSORS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSORS-1:0]  e,
  output logic                pulse_valid,
  input  logic                pulse_ready,
  output logic [SW-1:0]       pulse_sensor,
  output logic [TS_WIDTH-1:0] pulse_ts,
  output logic [W_WIDTH-1:0]  pulse_width,
  output logic                overflow
);

  localparam int RW = rec_w(SENSORS, TS_WIDTH, W_WIDTH);
  localparam int CW = (TS_WIDTH > W_WIDTH) ? TS_WIDTH : W_WIDTH;
  localparam logic [CW-1:0] WMAX = CW'({W_WIDTH{1'b1}});

  logic [SENSORS-1:0]  sync1_q, sync2_q, sync3_q, fall_q, rise_q;
  logic [1:0]          warm_q;
  logic                warm;
  logic [TS_WIDTH-1:0] cnt_q;

  sense_state_e        st_q    [SENSORS];
  sense_state_e        st_d    [SENSORS];
  logic [TS_WIDTH-1:0] start_q [SENSORS];
  logic [TS_WIDTH-1:0] start_d [SENSORS];
  logic [TS_WIDTH-1:0] pts_q   [SENSORS];
  logic [TS_WIDTH-1:0] pts_d   [SENSORS];
  logic [W_WIDTH-1:0]  pw_q    [SENSORS];
  logic [W_WIDTH-1:0]  pw_d    [SENSORS];
  logic [SENSORS-1:0]  pend_q, pend_d;
  logic [SW-1:0]       last_q, last_d;
  logic                ovf_q, ovf_d;

  logic                found, push, pop, fifo_full, fifo_empty;
  logic [SW-1:0]       sel, cand;
  logic [RW-1:0]       fifo_din, fifo_dout;

  // Sync chain resets high so an idle line does not look like an edge.
  // Edges are registered, giving a fixed 3-cycle pin-to-FSM delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      sync3_q <= '1;
      fall_q  <= '0;
      rise_q  <= '0;
      warm_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= e;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      fall_q  <= sync3_q & ~sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      cnt_q   <= cnt_q + TS_WIDTH'(1);
    end
  end

  // sync2 only holds a real pin sample two cycles after reset release;
  // before that its reset value must not arm the sensor.
  assign warm = (warm_q == 2'd2);

  assign pop = pulse_valid && pulse_ready;

  // Round-robin: search starts one past the last granted sensor.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= SENSORS; k++) begin
      cand = SW'((int'(last_q) + k) % SENSORS);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    push     = found && (!fifo_full || pop);
    fifo_din = {sel, pts_q[sel], pw_q[sel]};
  end

  always_comb begin
    logic [TS_WIDTH-1:0] diff;
    logic [W_WIDTH-1:0]  wsat;
    logic                gnt;
    diff   = '0;
    wsat   = '0;
    gnt    = 1'b0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    last_d = push ? sel : last_q;
    for (int i = 0; i < SENSORS; i++) begin
      st_d[i]    = st_q[i];
      start_d[i] = start_q[i];
      pts_d[i]   = pts_q[i];
      pw_d[i]    = pw_q[i];
      gnt        = push && (int'(sel) == i);
      if (gnt) pend_d[i] = 1'b0;
      diff = cnt_q - start_q[i];
      wsat = (CW'(diff) > WMAX) ? '1 : W_WIDTH'(diff);
      case (st_q[i])
        S_DISARMED: if (warm && sync2_q[i]) st_d[i] = S_IDLE;
        S_IDLE: begin
          if (fall_q[i]) begin
            st_d[i]    = S_ACTIVE;
            start_d[i] = cnt_q;
          end
        end
        S_ACTIVE: begin
          if (rise_q[i]) begin
            st_d[i] = S_IDLE;
            if (int'(wsat) >= MIN_WIDTH) begin
              // Unsent record still waiting: it is replaced, and lost.
              if (pend_q[i] && !gnt) ovf_d = 1'b1;
              pend_d[i] = 1'b1;
              pts_d[i]  = start_q[i];
              pw_d[i]   = wsat;
            end
          end
        end
        default: st_d[i] = S_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SENSORS; i++) begin
        st_q[i]    <= S_DISARMED;
        start_q[i] <= '0;
        pts_q[i]   <= '0;
        pw_q[i]    <= '0;
      end
      pend_q <= '0;
      last_q <= SW'(SENSORS - 1);
      ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < SENSORS; i++) begin
        st_q[i]    <= st_d[i];
        start_q[i] <= start_d[i];
        pts_q[i]   <= pts_d[i];
        pw_q[i]    <= pw_d[i];
      end
      pend_q <= pend_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
    end
  end

  pulse_fifo #(
    .DW    (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pulse_valid = !fifo_empty;
  assign {pulse_sensor, pulse_ts, pulse_width} = fifo_dout;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_capture.sv
module tb_pulse_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  e = 2'b11;
  logic        pulse_ready = 1'b1;
  logic        pulse_valid;
  logic [0:0]  pulse_sensor;
  logic [23:0] pulse_ts;
  logic [15:0] pulse_width;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Expected free-running counter value: edges since reset release.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  pulse_capture dut (
    .clk          (clk),
    .reset        (reset),
    .e            (e),
    .pulse_valid  (pulse_valid),
    .pulse_ready  (pulse_ready),
    .pulse_sensor (pulse_sensor),
    .pulse_ts     (pulse_ts),
    .pulse_width  (pulse_width),
    .overflow     (overflow)
  );

  typedef struct {
    logic [1:0] mask;
    int         len;
    bit         rec;
    int         sensor;
    int         width;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit seen, output int at);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pulse_valid === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  // Hold the masked lines low for len cycles; called just after a posedge.
  task automatic low(input logic [1:0] mask, input int len, output int f, output int r);
    e = e & ~mask;
    f = cyc;
    step(len);
    e = e | mask;
    r = cyc;
  endtask

  function automatic int ts_of(input int f);
    return (f + 3) & 32'h00FF_FFFF;
  endfunction

  int  f, r, at;
  bit  seen;
  int  exp_ts[10];
  int  exp_w[10];
  int  idx;

  initial begin
    vecs[0] = '{mask: 2'b01, len: 100, rec: 1'b1, sensor: 0, width: 100};
    vecs[1] = '{mask: 2'b01, len: 2,   rec: 1'b1, sensor: 0, width: 2};
    vecs[2] = '{mask: 2'b10, len: 37,  rec: 1'b1, sensor: 1, width: 37};
    vecs[3] = '{mask: 2'b01, len: 1,   rec: 1'b0, sensor: 0, width: 0};
    vecs[4] = '{mask: 2'b10, len: 1,   rec: 1'b0, sensor: 0, width: 0};

    // Reset state
    step(3);
    check("rst_valid", pulse_valid, 0);
    check("rst_sensor", pulse_sensor, 0);
    check("rst_ts", pulse_ts, 0);
    check("rst_width", pulse_width, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    step(10);

    // Single pulses, one at a time, empty FIFO
    for (int v = 0; v < 5; v++) begin
      low(vecs[v].mask, vecs[v].len, f, r);
      if (vecs[v].rec) begin
        wait_valid(12, seen, at);
        check($sformatf("v%0d_valid", v), seen, 1);
        check($sformatf("v%0d_sensor", v), pulse_sensor, vecs[v].sensor);
        check($sformatf("v%0d_width", v), pulse_width, vecs[v].width);
        check($sformatf("v%0d_ts", v), pulse_ts, ts_of(f));
        check($sformatf("v%0d_latency", v), at - r, 5);
      end else begin
        wait_valid(15, seen, at);
        check($sformatf("v%0d_norec", v), seen, 0);
      end
      step(1);
      step(5);
    end
    check("glitch_ovf", overflow, 0);

    // Simultaneous release on both sensors
    e = 2'b00;
    f = cyc;
    step(50);
    e = 2'b11;
    r = cyc;
    wait_valid(12, seen, at);
    check("sim_a_valid", seen, 1);
    check("sim_a_sensor", pulse_sensor, 0);
    check("sim_a_width", pulse_width, 50);
    check("sim_a_ts", pulse_ts, ts_of(f));
    wait_valid(3, seen, at);
    check("sim_b_valid", seen, 1);
    check("sim_b_sensor", pulse_sensor, 1);
    check("sim_b_width", pulse_width, 50);
    check("sim_b_ts", pulse_ts, ts_of(f));
    check("sim_b_at", at - r, 6);
    step(1);
    step(5);

    // Back-pressure: 10 pulses into an 8-deep FIFO
    pulse_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      low(2'b01, 10 + k, f, r);
      exp_ts[k] = ts_of(f);
      exp_w[k]  = 10 + k;
      step(12);
    end
    step(10);
    @(negedge clk);
    check("bp_ovf", overflow, 1);
    check("bp_valid", pulse_valid, 1);
    check("bp_head_width", pulse_width, exp_w[0]);
    step(1);
    pulse_ready = 1'b1;
    // Eight in order, then the surviving pending record (pulse 10)
    for (int j = 0; j < 9; j++) begin
      idx = (j < 8) ? j : 9;
      wait_valid(3, seen, at);
      check($sformatf("drain%0d_valid", j), seen, 1);
      check($sformatf("drain%0d_width", j), pulse_width, exp_w[idx]);
      check($sformatf("drain%0d_ts", j), pulse_ts, exp_ts[idx]);
      check($sformatf("drain%0d_sensor", j), pulse_sensor, 0);
    end
    wait_valid(5, seen, at);
    check("drain_empty", seen, 0);
    step(1);

    // Saturated width
    low(2'b10, 70000, f, r);
    wait_valid(12, seen, at);
    check("sat_valid", seen, 1);
    check("sat_sensor", pulse_sensor, 1);
    check("sat_width", pulse_width, 65535);
    check("sat_ts", pulse_ts, ts_of(f));
    step(1);
    step(5);

    // Reset mid-pulse with the line still low at release
    e[0] = 1'b0;
    step(30);
    reset = 1'b1;
    step(3);
    check("rst2_ovf", overflow, 0);
    check("rst2_valid", pulse_valid, 0);
    reset = 1'b0;
    step(20);
    e[0] = 1'b1;
    wait_valid(20, seen, at);
    check("rst2_norec", seen, 0);
    step(1);
    step(5);
    low(2'b01, 40, f, r);
    wait_valid(12, seen, at);
    check("rst2_valid_rec", seen, 1);
    check("rst2_width", pulse_width, 40);
    check("rst2_ts", pulse_ts, ts_of(f));
    check("rst2_sensor", pulse_sensor, 0);
    step(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
